// File: rtl/mux2to1_4bit_pkg.sv
// mux2to1_4bit_pkg: shared width default and register reset value for mux2to1_4bit
package mux2to1_4bit_pkg;
    localparam int DEF_WIDTH = 4;
    localparam logic RST_BIT = 1'b0;
endpackage

// File: rtl/mux2to1_4bit_mux2_cell.sv
// mux2_cell: parameterised WIDTH-bit combinational 2:1 selector
// Ports: in1 (chosen when sel=1), in2 (chosen when sel=0), sel, out
module mux2_cell #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    // The ?: operator merges agreeing bits when sel is unknown.
    assign out = sel ? in1 : in2;
endmodule

// File: rtl/mux2to1_4bit.sv
// mux2to1_4bit: 2:1 operand mux with registered copy, registered select and change strobe
// Ports: clk, rst_n (async active-low, register stage only), in1, in2, sel,
//        out_mux2_1 (combinational), out_mux2_1_q, sel_q, out_chg (registered)
module mux2to1_4bit
    import mux2to1_4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out_mux2_1,
    output logic [WIDTH-1:0] out_mux2_1_q,
    output logic             sel_q,
    output logic             out_chg
);
    mux2_cell #(.WIDTH(WIDTH)) u_cell (
        .in1 (in1),
        .in2 (in2),
        .sel (sel),
        .out (out_mux2_1)
    );
    // Strobe compares the incoming value against the one being replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_mux2_1_q <= {WIDTH{RST_BIT}};
            sel_q        <= 1'b0;
            out_chg      <= 1'b0;
        end else begin
            out_mux2_1_q <= out_mux2_1;
            sel_q        <= sel;
            out_chg      <= out_mux2_1 != out_mux2_1_q;
        end
    end
endmodule

// File: tb/tb_mux2to1_4bit.sv
// tb_mux2to1_4bit: randomized self-checking bench for mux2to1_4bit
module tb_mux2to1_4bit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in1, in2;
    logic       sel;
    logic [3:0] out_mux2_1, out_mux2_1_q;
    logic       sel_q, out_chg;
    int checks = 0;
    int errors = 0;
    logic [3:0] prev_q;

    mux2to1_4bit #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in1          (in1),
        .in2          (in2),
        .sel          (sel),
        .out_mux2_1   (out_mux2_1),
        .out_mux2_1_q (out_mux2_1_q),
        .sel_q        (sel_q),
        .out_chg      (out_chg)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_mux(input logic s, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] src [2];
        src[0] = b;
        src[1] = a;
        return src[s];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Load edge: expected register contents come from inputs seen just before the edge.
    task automatic tick();
        logic [3:0] exp_q;
        logic       exp_s;
        exp_q = ref_mux(sel, in1, in2);
        exp_s = sel;
        @(posedge clk);
        #1;
        check("reg_q", out_mux2_1_q, exp_q);
        check("sel_q", sel_q, exp_s);
        check("chg", out_chg, exp_q != prev_q);
        prev_q = exp_q;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in1 = 4'h0;
        in2 = 4'h0;
        sel = 1'b0;
        #1;
        check("rst_q", out_mux2_1_q, 0);
        check("rst_sel_q", sel_q, 0);
        check("rst_chg", out_chg, 0);
        in1 = 4'hA;
        in2 = 4'h5;
        sel = 1'b0;
        #1 check("sweep0", out_mux2_1, 4'h5);
        sel = 1'b1;
        #1 check("sweep1", out_mux2_1, 4'hA);
        sel = 1'b0;
        #1 check("sweep2", out_mux2_1, 4'h5);
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in1 = 4'($urandom_range(0, 15));
            in2 = 4'($urandom);
            #1 check("track", out_mux2_1, in1);
            in2 = ~in2;
            #1 check("track_in2", out_mux2_1, in1);
            #18;
        end
        for (int t = 0; t < 100; t += 10) begin
            if (t == 0 || t == 30) sel = 1'b0;
            if (t == 10 || t == 80) sel = 1'b1;
            if (t % 20 == 0) begin
                in1 = 4'($urandom);
                in2 = 4'($urandom);
            end
            #1 check("timed", out_mux2_1, ref_mux(sel, in1, in2));
            #9;
        end
        check("held_q", out_mux2_1_q, 0);
        @(posedge clk);
        #2;
        in1 = 4'h3;
        in2 = 4'hC;
        sel = 1'b1;
        rst_n = 1'b1;
        prev_q = 4'h0;
        tick();
        tick();
        for (int i = 0; i < 24; i++) begin
            if (i % 3 != 2) begin
                in1 = 4'($urandom);
                in2 = 4'($urandom);
                sel = 1'($urandom);
            end
            tick();
            check("rand_comb", out_mux2_1, ref_mux(sel, in1, in2));
        end
        in1 = 4'h9;
        sel = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", out_mux2_1_q, 0);
        check("arst_sel_q", sel_q, 0);
        check("arst_chg", out_chg, 0);
        in1 = 4'h6;
        #1 check("arst_comb", out_mux2_1, 4'h6);
        @(posedge clk);
        #1 check("arst_hold", out_mux2_1_q, 0);
        #2;
        rst_n = 1'b1;
        prev_q = 4'h0;
        in1 = 4'h0;
        in2 = 4'h0;
        tick();
        in2 = 4'hE;
        sel = 1'b0;
        tick();
        in1 = 4'h7;
        in2 = 4'h7;
        sel = 1'bx;
        #1 check("xsel", out_mux2_1, 4'h7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
